// File: rtl/crc_check.sv
// crc_check: receive-side CRC5/CRC16 residual checker with length error detection.
module crc_check #(
  parameter int CNT_W = 14
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clear,
  input  logic             start,
  input  logic             pkttype,
  input  logic             recving,
  input  logic             inb,
  input  logic             pause,
  output logic             done,
  output logic             crc_ok,
  output logic             crc_err,
  output logic             len_err,
  output logic [CNT_W-1:0] bit_cnt
);
  typedef enum logic [1:0] {IDLE, CHECK, REPORT} state_t;
  localparam logic [4:0]  POLY5 = 5'b00101;
  localparam logic [15:0] POLY16 = 16'h8005;
  localparam logic [4:0]  RES5 = 5'b01100;
  localparam logic [15:0] RES16 = 16'h800D;
  state_t state_q, state_d;
  logic [4:0] crc5_q, crc5_d, crc5_n;
  logic [15:0] crc16_q, crc16_d, crc16_n;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic type_q, type_d, done_q, done_d, ok_q, ok_d, err_q, err_d, len_q, len_d;
  logic short_pkt, res_ok;
  assign crc5_n = {crc5_q[3:0], 1'b0} ^ ((inb ^ crc5_q[4]) ? POLY5 : 5'h00);
  assign crc16_n = {crc16_q[14:0], 1'b0} ^ ((inb ^ crc16_q[15]) ? POLY16 : 16'h0000);
  assign short_pkt = cnt_q < (type_q ? CNT_W'(16) : CNT_W'(5));
  assign res_ok = type_q ? (crc16_q == RES16) : (crc5_q == RES5);
  always_comb begin
    state_d = state_q;
    crc5_d = crc5_q;
    crc16_d = crc16_q;
    cnt_d = cnt_q;
    type_d = type_q;
    done_d = 1'b0;
    ok_d = ok_q;
    err_d = err_q;
    len_d = len_q;
    if (clear) begin
      state_d = IDLE;
      crc5_d = 5'h1F;
      crc16_d = 16'hFFFF;
      cnt_d = '0;
      ok_d = 1'b0;
      err_d = 1'b0;
      len_d = 1'b0;
    end else if (start && state_q != REPORT) begin
      state_d = CHECK;
      type_d = pkttype;
      crc5_d = 5'h1F;
      crc16_d = 16'hFFFF;
      cnt_d = '0;
      ok_d = 1'b0;
      err_d = 1'b0;
      len_d = 1'b0;
    end else if (state_q == CHECK && !recving) begin
      state_d = REPORT;
      done_d = 1'b1;
      len_d = short_pkt;
      ok_d = !short_pkt && res_ok;
      err_d = !short_pkt && !res_ok;
    end else if (state_q == CHECK && !pause) begin
      crc5_d = crc5_n;
      crc16_d = crc16_n;
      cnt_d = (&cnt_q) ? cnt_q : cnt_q + 1'b1;
    end else if (state_q == REPORT) begin
      state_d = IDLE;
      crc5_d = 5'h1F;
      crc16_d = 16'hFFFF;
    end
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      crc5_q <= 5'h1F;
      crc16_q <= 16'hFFFF;
      cnt_q <= '0;
      type_q <= 1'b0;
      done_q <= 1'b0;
      ok_q <= 1'b0;
      err_q <= 1'b0;
      len_q <= 1'b0;
    end else begin
      state_q <= state_d;
      crc5_q <= crc5_d;
      crc16_q <= crc16_d;
      cnt_q <= cnt_d;
      type_q <= type_d;
      done_q <= done_d;
      ok_q <= ok_d;
      err_q <= err_d;
      len_q <= len_d;
    end
  end
  assign done = done_q;
  assign crc_ok = ok_q;
  assign crc_err = err_q;
  assign len_err = len_q;
  assign bit_cnt = cnt_q;
endmodule

// File: tb/tb_crc_check.sv
// tb_crc_check: directed checks of crc_check against hand-computed CRC outcomes.
module tb_crc_check;
  logic clk = 1'b0, rst = 1'b1, clear = 1'b0, start = 1'b0, pkttype = 1'b0;
  logic recving = 1'b0, inb = 1'b0, pause = 1'b0;
  logic done, crc_ok, crc_err, len_err;
  logic [13:0] bit_cnt;
  int total = 0, bad = 0;
  crc_check dut (
    .clk(clk), .rst(rst), .clear(clear), .start(start), .pkttype(pkttype),
    .recving(recving), .inb(inb), .pause(pause), .done(done), .crc_ok(crc_ok),
    .crc_err(crc_err), .len_err(len_err), .bit_cnt(bit_cnt)
  );
  always #5 clk = ~clk;
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask
  task automatic step;
    @(posedge clk);
    #1;
  endtask
  task automatic begin_pkt(input logic t);
    start = 1'b1;
    pkttype = t;
    recving = 1'b0;
    step;
    start = 1'b0;
  endtask
  task automatic shift_bits(input logic [31:0] d, input int n, input int pa);
    for (int i = n - 1; i >= 0; i--) begin
      if (n - 1 - i == pa)
        repeat (3) begin
          recving = 1'b1;
          pause = 1'b1;
          inb = 1'b1;
          step;
        end
      recving = 1'b1;
      pause = 1'b0;
      inb = d[i];
      step;
    end
  endtask
  task automatic end_pkt;
    recving = 1'b0;
    pause = 1'b0;
    inb = 1'b0;
    step;
  endtask
  task automatic check_flags(input string tag, input logic [3:0] exp, input int cnt);
    check({tag, "_flags"}, {done, crc_ok, crc_err, len_err}, exp);
    check({tag, "_cnt"}, 32'(bit_cnt), 32'(cnt));
  endtask
  initial begin
    step;
    step;
    check_flags("reset", 4'b0000, 0);
    rst = 1'b0;
    step;
    // good token: 11 zeros then 0,1,0,0,0 leaves the residual 01100
    begin_pkt(1'b0);
    shift_bits(32'h0008, 16, -1);
    check("busy_no_done", done, 0);
    end_pkt;
    check_flags("crc5_good", 4'b1100, 16);
    step;
    check_flags("crc5_good_hold", 4'b0100, 16);
    begin_pkt(1'b0);
    check_flags("start_clears", 4'b0000, 0);
    shift_bits(32'h0408, 16, -1);
    end_pkt;
    check_flags("crc5_bad", 4'b1010, 16);
    step;
    begin_pkt(1'b1);
    shift_bits(32'h0000, 16, -1);
    end_pkt;
    check_flags("crc16_empty", 4'b1100, 16);
    step;
    begin_pkt(1'b0);
    shift_bits(32'h0008, 16, 8);
    end_pkt;
    check_flags("crc5_pause", 4'b1100, 16);
    step;
    begin_pkt(1'b1);
    shift_bits(32'h5, 3, -1);
    end_pkt;
    check_flags("crc16_short", 4'b1001, 3);
    step;
    begin_pkt(1'b0);
    shift_bits(32'h0, 4, -1);
    end_pkt;
    check_flags("crc5_len4", 4'b1001, 4);
    step;
    begin_pkt(1'b0);
    shift_bits(32'h0, 5, -1);
    end_pkt;
    check("crc5_len5_nolen", len_err, 0);
    check("crc5_len5_verdict", crc_ok ^ crc_err, 1);
    step;
    begin_pkt(1'b0);
    shift_bits(32'h1F, 5, -1);
    clear = 1'b1;
    recving = 1'b1;
    step;
    clear = 1'b0;
    check_flags("clear_mid", 4'b0000, 0);
    recving = 1'b0;
    step;
    step;
    check_flags("clear_no_done", 4'b0000, 0);
    clear = 1'b1;
    start = 1'b1;
    step;
    clear = 1'b0;
    start = 1'b0;
    step;
    step;
    check_flags("clear_beats_start", 4'b0000, 0);
    begin_pkt(1'b1);
    shift_bits(32'h1B, 5, -1);
    start = 1'b1;
    pkttype = 1'b0;
    recving = 1'b1;
    step;
    start = 1'b0;
    check("restart_no_done", done, 0);
    shift_bits(32'h0008, 16, -1);
    end_pkt;
    check_flags("restart_good", 4'b1100, 16);
    start = 1'b1;
    step;
    start = 1'b0;
    check_flags("start_in_report", 4'b0100, 16);
    step;
    check_flags("report_start_lost", 4'b0100, 16);
    begin_pkt(1'b1);
    shift_bits(32'h3, 6, -1);
    rst = 1'b1;
    step;
    rst = 1'b0;
    check_flags("rst_mid", 4'b0000, 0);
    recving = 1'b0;
    step;
    check_flags("rst_idle", 4'b0000, 0);
    begin_pkt(1'b0);
    recving = 1'b1;
    pause = 1'b0;
    inb = 1'b0;
    repeat (16390) step;
    check("sat_cnt", 32'(bit_cnt), 32'h3FFF);
    end_pkt;
    check("sat_done", done, 1);
    check("sat_cnt_hold", 32'(bit_cnt), 32'h3FFF);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
